// File: rtl/mac_frame_accum.sv
// mac_frame_accum: per-frame accumulation of (x+y), q and max(p), handed off on a valid/ready port.
// Ports: clk, rst (async, active-high); in_valid/in_ready sample handshake with x, y, p, q and flush;
// out_valid/out_ready result handshake with sum_acc, diff_acc, p_max, cnt, ovf.
// Compile-time option: MAC_FRAME_ACC_SAT_EN makes both accumulators saturate instead of wrap.
module mac_frame_accum #(
  parameter int LEN   = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32:0]      x,
  input  logic [32:0]      y,
  input  logic [16:0]      p,
  input  logic [16:0]      q,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_acc,
  output logic [ACC_W-1:0] diff_acc,
  output logic [16:0]      p_max,
  output logic [7:0]       cnt,
  output logic             ovf
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t           state_q;
  logic [ACC_W-1:0] sum_q, diff_q, sum_d, diff_d, q_ext, diff_raw;
  logic [ACC_W:0]   sum_full;
  logic [16:0]      pmax_q, pmax_d;
  logic [7:0]       cnt_q;
  logic             ovf_q, carry, sovf, take, close;
`ifdef MAC_FRAME_ACC_SAT_EN
  logic             dsat_q;
`endif
  assign take  = (state_q == ACC) && in_valid;
  assign close = (take && ({1'b0, cnt_q} + 9'd1 == 9'(LEN))) ||
                 ((state_q == ACC) && flush && (in_valid || cnt_q != 8'd0));
  always_comb begin
    sum_full = {1'b0, sum_q} + (ACC_W+1)'({1'b0, x} + {1'b0, y});
    q_ext    = {{(ACC_W-17){q[16]}}, q};
    diff_raw = diff_q + q_ext;
    carry    = sum_full[ACC_W];
    sovf     = (diff_q[ACC_W-1] == q[16]) && (diff_raw[ACC_W-1] != diff_q[ACC_W-1]);
`ifdef MAC_FRAME_ACC_SAT_EN
    sum_d    = carry ? '1 : sum_full[ACC_W-1:0];
    // once diff has hit a rail it is pinned there until the frame is handed off
    diff_d   = dsat_q ? diff_q :
               sovf   ? {diff_q[ACC_W-1], {(ACC_W-1){~diff_q[ACC_W-1]}}} : diff_raw;
`else
    sum_d    = sum_full[ACC_W-1:0];
    diff_d   = diff_raw;
`endif
    pmax_d   = (p > pmax_q) ? p : pmax_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      sum_q   <= '0;
      diff_q  <= '0;
      pmax_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef MAC_FRAME_ACC_SAT_EN
      dsat_q  <= 1'b0;
`endif
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        state_q <= ACC;
        sum_q   <= '0;
        diff_q  <= '0;
        pmax_q  <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
`ifdef MAC_FRAME_ACC_SAT_EN
        dsat_q  <= 1'b0;
`endif
      end
    end else begin
      if (take) begin
        sum_q  <= sum_d;
        diff_q <= diff_d;
        pmax_q <= pmax_d;
        cnt_q  <= cnt_q + 8'd1;
        ovf_q  <= ovf_q | carry | sovf;
`ifdef MAC_FRAME_ACC_SAT_EN
        dsat_q <= dsat_q | sovf;
`endif
      end
      if (close) state_q <= HOLD;
    end
  end
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign sum_acc   = sum_q;
  assign diff_acc  = diff_q;
  assign p_max     = pmax_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_mac_frame_accum.sv
// tb_mac_frame_accum: directed and randomized checks of mac_frame_accum against a behavioural model.
module tb_mac_frame_accum;
  localparam int LEN = 4;
  localparam int W   = 40;
`ifdef MAC_FRAME_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [63:0] SMOD = 64'd1 << W;
  localparam longint      DMAX = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint      DMIN = -(64'sd1 <<< (W-1));

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [32:0] x = '0, y = '0;
  logic [16:0] p = '0, q = '0;
  logic        in_ready, out_valid, ovf;
  logic [W-1:0] sum_acc, diff_acc;
  logic [16:0] p_max;
  logic [7:0]  cnt;

  mac_frame_accum #(.LEN(LEN), .ACC_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .p(p), .q(q),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .sum_acc(sum_acc),
    .diff_acc(diff_acc), .p_max(p_max), .cnt(cnt), .ovf(ovf));

  logic        v2 = 1'b0;
  logic [32:0] x2 = '0;
  logic        ir2, ov2, ovf2;
  logic [33:0] sum2, diff2;
  logic [16:0] pm2;
  logic [7:0]  cnt2;

  mac_frame_accum #(.LEN(LEN), .ACC_W(34)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .x(x2), .y(x2), .p(17'd0), .q(17'd0),
    .flush(1'b0), .out_valid(ov2), .out_ready(1'b0), .sum_acc(sum2), .diff_acc(diff2),
    .p_max(pm2), .cnt(cnt2), .ovf(ovf2));

  int tests = 0, fails = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // behavioural model: exact arithmetic, then wrap or clamp against the accumulator range
  bit          m_hold = 0, m_ovf = 0, m_dsat = 0;
  logic [63:0] m_sum = 0, mt;
  longint      m_diff = 0, md;
  int          m_pmax = 0, m_cnt = 0;

  task automatic m_clear();
    m_sum = 0; m_diff = 0; m_pmax = 0; m_cnt = 0; m_ovf = 0; m_dsat = 0; m_hold = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_clear();
    else if (m_hold) begin
      if (out_ready) m_clear();
    end else begin
      if (in_valid) begin
        mt = m_sum + 64'(x) + 64'(y);
        if (mt >= SMOD) begin
          m_ovf = 1;
          mt = SAT ? SMOD - 64'd1 : mt - SMOD;
        end
        m_sum = mt;
        if (!m_dsat) begin
          md = m_diff + longint'($signed(q));
          if (md > DMAX || md < DMIN) begin
            m_ovf = 1;
            if (SAT) begin
              m_dsat = 1;
              md = (md > DMAX) ? DMAX : DMIN;
            end else md = (md > DMAX) ? md - longint'(SMOD) : md + longint'(SMOD);
          end
          m_diff = md;
        end
        if (int'(p) > m_pmax) m_pmax = int'(p);
        m_cnt++;
      end
      if ((in_valid && m_cnt == LEN) || (flush && m_cnt > 0)) m_hold = 1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!m_hold));
    chk("out_valid", 64'(out_valid), 64'(m_hold));
    chk("sum_acc", 64'(sum_acc), m_sum);
    chk("diff_acc", 64'(diff_acc), 64'(m_diff[W-1:0]));
    chk("p_max", 64'(p_max), 64'(m_pmax));
    chk("cnt", 64'(cnt), 64'(m_cnt));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  end

  task automatic drive(bit v, logic [32:0] xx, logic [32:0] yy, logic [16:0] pp, logic [16:0] qq,
                       bit f, bit r);
    in_valid = v; x = xx; y = yy; p = pp; q = qq; flush = f; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    in_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
  endtask

  task automatic frame_a();
    drive(1, 33'd1, 33'd10, 17'd5, 17'h1FFFF, 0, 0);
    drive(1, 33'd2, 33'd10, 17'd9, 17'h1FFFF, 0, 0);
    drive(1, 33'd3, 33'd10, 17'd3, 17'h1FFFF, 0, 0);
    drive(1, 33'd4, 33'd10, 17'd7, 17'h1FFFF, 0, 0);
    chk("frame out_valid", 64'(out_valid), 64'd1);
    chk("frame sum", 64'(sum_acc), 64'd50);
    chk("frame diff", 64'(diff_acc), 64'hFF_FFFF_FFFC);
    chk("frame pmax", 64'(p_max), 64'd9);
    chk("frame cnt", 64'(cnt), 64'd4);
    chk("frame ovf", 64'(ovf), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    @(posedge clk); #1 rst = 0;
    drive(1, 33'd5, 33'd6, 17'd1, 17'd1, 0, 0);
    @(posedge clk); #3 rst = 1;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    chk("async rst sum", 64'(sum_acc), 64'd0);
    chk("async rst cnt", 64'(cnt), 64'd0);
    @(posedge clk); #3 rst = 0;
    drive(1, 33'd5, 33'd6, 17'd1, 17'd1, 0, 0);
    chk("first accept cnt", 64'(cnt), 64'd1);
    chk("first accept sum", 64'(sum_acc), 64'd11);
    do_rst();
    frame_a();
    repeat (3) drive(1, 33'd99, 33'd99, 17'd99, 17'd3, 0, 0);
    chk("bp cnt", 64'(cnt), 64'd4);
    chk("bp sum", 64'(sum_acc), 64'd50);
    chk("bp in_ready", 64'(in_ready), 64'd0);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 0, 1);
    chk("handoff out_valid", 64'(out_valid), 64'd0);
    chk("handoff cnt", 64'(cnt), 64'd0);
    chk("handoff in_ready", 64'(in_ready), 64'd1);
    repeat (2) drive(1, 33'd7, 33'd1, 17'd0, 17'd0, 0, 0);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 1, 0);
    chk("flush out_valid", 64'(out_valid), 64'd1);
    chk("flush sum", 64'(sum_acc), 64'd16);
    chk("flush cnt", 64'(cnt), 64'd2);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 0, 1);
    repeat (2) drive(1, 33'd7, 33'd1, 17'd0, 17'd0, 0, 0);
    drive(1, 33'd7, 33'd1, 17'd0, 17'd0, 1, 0);
    chk("flush+sample sum", 64'(sum_acc), 64'd24);
    chk("flush+sample cnt", 64'(cnt), 64'd3);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 0, 1);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 1, 0);
    chk("empty flush out_valid", 64'(out_valid), 64'd0);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 0, 0);
    v2 = 1; x2 = '1;
    repeat (2) @(posedge clk);
    #1 v2 = 0;
    chk("ovf34 sum", 64'(sum2), SAT ? 64'h3_FFFF_FFFF : 64'h3_FFFF_FFFC);
    chk("ovf34 ovf", 64'(ovf2), 64'd1);
    do_rst();
    repeat (3) drive(1, 33'd9, 33'd9, 17'd9, 17'd9, 0, 0);
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 0, 0);
    #2 rst = 1;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst cnt", 64'(cnt), 64'd0);
    @(posedge clk); #2 rst = 0;
    frame_a();
    drive(0, 33'd0, 33'd0, 17'd0, 17'd0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) r = '1;
      drive($urandom_range(0, 3) != 0, r[32:0], ($urandom_range(0, 7) == 0) ? '1 : 33'({$urandom, 1'b0}),
            17'($urandom), 17'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_frame_accum.md
# mac_frame_accum

Registered accumulation stage that sits directly downstream of the combinational multiply/add datapath. It consumes one result set (x, y, p, q) per handshake, accumulates over a frame of LEN samples or until flush, and presents per-frame totals on a valid/ready output. This is the first clocked stage after the arithmetic block.

## Interface
- LEN, 8: samples per frame; 1..255.
- ACC_W, 40: accumulator width; must be ≥ 34.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  stage can accept a sample
- x  in  33  unsigned sum result
- y  in  33  unsigned product/sum result
- p  in  17  unsigned c+d result
- q  in  17  c−d result, two's complement
- flush  in  1  close the current frame early
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- sum_acc  out  ACC_W  Σ(x+y), unsigned
- diff_acc  out  ACC_W  Σq, signed
- p_max  out  17  maximum p in frame
- cnt  out  8  samples in frame
- ovf  out  1  sticky overflow of either accumulator within frame

## Operation
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- Reset forces ACC. All outputs and accumulators go to 0, in_ready=1, out_valid=0.
- ACC, on in_valid:
  - sum_acc += zext(x)+zext(y); the 34-bit sum is zero-extended to ACC_W.
  - diff_acc += sext(q).
  - p_max = max(p_max, p), unsigned.
  - cnt += 1.
- Frame closes on the accepting edge when cnt reaches LEN. The closing sample is included. State goes to HOLD.
- flush in ACC with cnt>0 and no in_valid: go to HOLD, totals unchanged.
- flush together with in_valid: the sample is included, then go to HOLD.
- flush with cnt=0 and no in_valid: ignored.
- HOLD:
  - All outputs are held stable.
  - in_valid and flush are ignored.
  - On out_valid && out_ready: clear sum_acc, diff_acc, p_max, cnt and ovf to 0, return to ACC.
- Arithmetic wraps modulo 2^ACC_W unless saturation is compiled in (see Configuration).
- ovf sets on:
  - carry out of the sum_acc add, or
  - signed overflow of the diff_acc add.
- ovf clears only on result handoff or on reset.
- Reset mid-frame or during HOLD discards all partial state immediately, with no output.

## Timing
- Accept: in_valid && in_ready at a rising edge.
- Result: out_valid rises on the edge that accepts the LEN-th sample or the flush, so results are visible in the following cycle. Latency is 1 cycle from the last accept.
- in_ready is a registered state decode and has no combinational path from out_ready.
  - Consequence: one idle cycle per frame, i.e. throughput LEN samples per LEN+1 cycles when out_ready=1.
- After the handoff edge, in_ready=1 and the next sample can be accepted in the next cycle.
- Totals, cnt and ovf change only on accepting edges or the handoff edge.

## Configuration
- MAC_FRAME_ACC_SAT_EN defined:
  - sum_acc saturates at 2^ACC_W−1.
  - diff_acc saturates at +2^(ACC_W−1)−1 and −2^(ACC_W−1), and stays at the rail for the rest of the frame.
  - ovf still sets.
- Undefined: both accumulators wrap modulo 2^ACC_W, and ovf still sets.

## Test plan
1. Reset (LEN=4, ACC_W=40):
   - Assert rst asynchronously mid-cycle → all outputs 0 and in_ready=1 immediately.
   - Release rst; the first sample is accepted on the next edge.
2. Full frame (LEN=4, ACC_W=40):
   - Stimulus: x=1,2,3,4; y=10 each; q=−1 each (17'h1FFFF); p=5,9,3,7.
   - Response the cycle after the 4th accept: out_valid=1, sum_acc=50, diff_acc=−4, p_max=9, cnt=4, ovf=0.
3. Backpressure (LEN=4, ACC_W=40):
   - Hold out_ready=0 for 3 cycles after out_valid with in_valid=1 → outputs stable, in_ready=0, no samples consumed.
   - Raise out_ready → next cycle out_valid=0, cnt=0, in_ready=1.
4. Flush (LEN=4, ACC_W=40):
   - Two samples x=7, y=1, then flush with no in_valid → sum_acc=16, cnt=2.
   - Flush concurrent with a third sample instead → sum_acc=24, cnt=3.
   - Flush when cnt=0 → no out_valid.
5. Overflow (ACC_W=34):
   - Stimulus: two samples with x=y=2^33−1.
   - Wrap build: sum_acc=2^34−4, ovf=1.
   - MAC_FRAME_ACC_SAT_EN build: sum_acc=2^34−1, ovf=1.
6. Reset mid-frame (LEN=4, ACC_W=40):
   - Three samples accepted, then pulse rst → no out_valid, cnt=0.
   - A following full frame produces correct totals from zero.
